// File: rtl/hit_arbiter_pkg.sv
// Shared types and widths for the hit arbiter: FSM states, winner codes, counter widths.
package hit_arbiter_pkg;

  typedef enum logic [1:0] {
    StFight    = 2'd0,
    StFreeze   = 2'd1,
    StRoundEnd = 2'd2
  } arb_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int unsigned STUN_W  = 8;
  localparam int unsigned SCORE_W = 4;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                 input logic [SCORE_W-1:0] limit);
    return (score >= limit) ? limit : score + 1'b1;
  endfunction

endpackage

// File: rtl/hit_arbiter_tracker.sv
// Per-target tracker: stun counter, blockstun flag and the opposing attacker's armed flag.
module fighter_hit_tracker
  import hit_arbiter_pkg::*;
#(
  parameter int unsigned HITSTUN_FRAMES   = 20,
  parameter int unsigned BLOCKSTUN_FRAMES = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load_hit,
  input  logic load_block,
  input  logic dec_en,
  input  logic arm,
  input  logic disarm,
  output logic stun,
  output logic stun_blocked,
  output logic armed
);

  localparam logic [STUN_W-1:0] HitLoad   = STUN_W'(HITSTUN_FRAMES);
  localparam logic [STUN_W-1:0] BlockLoad = STUN_W'(BLOCKSTUN_FRAMES);

  logic [STUN_W-1:0] cnt_q;
  logic              blocked_q;
  logic              armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      blocked_q <= 1'b0;
      armed_q   <= 1'b1;
    end else if (clear) begin
      cnt_q     <= '0;
      blocked_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      if (load_hit) begin
        cnt_q     <= HitLoad;
        blocked_q <= 1'b0;
      end else if (load_block) begin
        cnt_q     <= BlockLoad;
        blocked_q <= 1'b1;
      end else if (dec_en && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // A registering connect always disarms, even if the attack flag dropped that frame.
      if (disarm) begin
        armed_q <= 1'b0;
      end else if (arm) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign stun         = (cnt_q != '0);
  assign stun_blocked = blocked_q & stun;
  assign armed        = armed_q;

endmodule

// File: rtl/hit_arbiter.sv
// Frame-rate hit referee: one connect per swing, hitstop, stun and scoring per round.
// HIT_ARBITER_TRADE_EN: same-tick double hits trade (both score) instead of clashing.
module hit_arbiter
  import hit_arbiter_pkg::*;
#(
  parameter int unsigned HITSTUN_FRAMES   = 20,
  parameter int unsigned BLOCKSTUN_FRAMES = 12,
  parameter int unsigned HITSTOP_FRAMES   = 6,
  parameter int unsigned WIN_SCORE        = 3,
  parameter int unsigned ROUND_END_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       p1_got_hit,
  input  logic       p1_got_blocked,
  input  logic       p2_got_hit,
  input  logic       p2_got_blocked,
  input  logic       p1_attack_flag,
  input  logic       p2_attack_flag,
  output logic       p1_stun,
  output logic       p2_stun,
  output logic       p1_stun_blocked,
  output logic       p2_stun_blocked,
  output logic       freeze,
  output logic       hit_event,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       round_over,
  output logic [1:0] winner
);

  localparam logic [SCORE_W-1:0] WinScore    = SCORE_W'(WIN_SCORE);
  localparam logic [STUN_W-1:0]  HitstopLoad = STUN_W'(HITSTOP_FRAMES);
  localparam logic [STUN_W-1:0]  RoundLoad   = STUN_W'(ROUND_END_FRAMES);

  arb_state_e         state_q;
  logic [STUN_W-1:0]  hitstop_q;
  logic [STUN_W-1:0]  round_q;
  logic [SCORE_W-1:0] p1_score_q;
  logic [SCORE_W-1:0] p2_score_q;
  logic [1:0]         winner_q;
  logic               freeze_q;
  logic               round_over_q;
  logic               hit_event_q;

  logic armed_p1;
  logic armed_p2;
  logic in_fight;
  logic ev_on_p1;
  logic ev_on_p2;
  logic any_ev;
  logic clash;
  logic p1_load_hit;
  logic p1_load_block;
  logic p2_load_hit;
  logic p2_load_block;
  logic dec_en;
  logic round_clear;
  logic p1_won;
  logic p2_won;

  assign in_fight = (state_q == StFight);

  // ev_on_pN: an event with pN as target, i.e. from the opposing attacker.
  assign ev_on_p1 = frame_tick & in_fight & armed_p2 & (p1_got_hit | p1_got_blocked);
  assign ev_on_p2 = frame_tick & in_fight & armed_p1 & (p2_got_hit | p2_got_blocked);
  assign any_ev   = ev_on_p1 | ev_on_p2;

`ifdef HIT_ARBITER_TRADE_EN
  assign clash = 1'b0;
`else
  assign clash = ev_on_p1 & ev_on_p2 & p1_got_hit & p2_got_hit;
`endif

  assign p1_load_hit   = ev_on_p1 & p1_got_hit & ~clash;
  assign p1_load_block = ev_on_p1 & ~p1_load_hit;
  assign p2_load_hit   = ev_on_p2 & p2_got_hit & ~clash;
  assign p2_load_block = ev_on_p2 & ~p2_load_hit;

  assign dec_en      = frame_tick & in_fight & ~any_ev;
  assign round_clear = frame_tick & (state_q == StRoundEnd) & (round_q <= 8'd1);
  assign p1_won      = (p1_score_q == WinScore);
  assign p2_won      = (p2_score_q == WinScore);

  fighter_hit_tracker #(
    .HITSTUN_FRAMES  (HITSTUN_FRAMES),
    .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES)
  ) u_p1_target (
    .clk         (clk),
    .rst         (rst),
    .clear       (round_clear),
    .load_hit    (p1_load_hit),
    .load_block  (p1_load_block),
    .dec_en      (dec_en),
    .arm         (frame_tick & ~p2_attack_flag),
    .disarm      (ev_on_p1),
    .stun        (p1_stun),
    .stun_blocked(p1_stun_blocked),
    .armed       (armed_p2)
  );

  fighter_hit_tracker #(
    .HITSTUN_FRAMES  (HITSTUN_FRAMES),
    .BLOCKSTUN_FRAMES(BLOCKSTUN_FRAMES)
  ) u_p2_target (
    .clk         (clk),
    .rst         (rst),
    .clear       (round_clear),
    .load_hit    (p2_load_hit),
    .load_block  (p2_load_block),
    .dec_en      (dec_en),
    .arm         (frame_tick & ~p1_attack_flag),
    .disarm      (ev_on_p2),
    .stun        (p2_stun),
    .stun_blocked(p2_stun_blocked),
    .armed       (armed_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFight;
      hitstop_q    <= '0;
      round_q      <= '0;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      winner_q     <= WIN_NONE;
      freeze_q     <= 1'b0;
      round_over_q <= 1'b0;
      hit_event_q  <= 1'b0;
    end else begin
      // Pulse is one clk wide, so it updates every cycle rather than per frame.
      hit_event_q <= any_ev;
      if (frame_tick) begin
        unique case (state_q)
          StFight: begin
            if (any_ev) begin
              hitstop_q <= HitstopLoad;
              freeze_q  <= 1'b1;
              state_q   <= StFreeze;
              if (p1_load_hit) p2_score_q <= sat_inc(p2_score_q, WinScore);
              if (p2_load_hit) p1_score_q <= sat_inc(p1_score_q, WinScore);
            end
          end
          StFreeze: begin
            if (hitstop_q <= 8'd1) begin
              hitstop_q <= '0;
              freeze_q  <= 1'b0;
              if (p1_won || p2_won) begin
                state_q      <= StRoundEnd;
                round_over_q <= 1'b1;
                round_q      <= RoundLoad;
                // Bit order matches the winner codes, so both set yields WIN_DRAW.
                winner_q     <= {p2_won, p1_won};
              end else begin
                state_q <= StFight;
              end
            end else begin
              hitstop_q <= hitstop_q - 1'b1;
            end
          end
          StRoundEnd: begin
            if (round_q <= 8'd1) begin
              round_q      <= '0;
              round_over_q <= 1'b0;
              winner_q     <= WIN_NONE;
              p1_score_q   <= '0;
              p2_score_q   <= '0;
              state_q      <= StFight;
            end else begin
              round_q <= round_q - 1'b1;
            end
          end
          default: state_q <= StFight;
        endcase
      end
    end
  end

  assign freeze     = freeze_q;
  assign hit_event  = hit_event_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign round_over = round_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_hit_arbiter.sv
// Bench for hit_arbiter: per-frame behavioural model checked every cycle, plus directed scenarios.
module tb_hit_arbiter;

  localparam int HS    = 6;
  localparam int HIT   = 20;
  localparam int BLK   = 12;
  localparam int WIN   = 3;
  localparam int REF   = 120;
`ifdef HIT_ARBITER_TRADE_EN
  localparam bit TRADE = 1'b1;
`else
  localparam bit TRADE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked;
  logic       p1_attack_flag, p2_attack_flag;
  logic       p1_stun, p2_stun, p1_stun_blocked, p2_stun_blocked;
  logic       freeze, hit_event, round_over;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;

  always #5 clk = ~clk;

  hit_arbiter #(
    .HITSTUN_FRAMES  (HIT),
    .BLOCKSTUN_FRAMES(BLK),
    .HITSTOP_FRAMES  (HS),
    .WIN_SCORE       (WIN),
    .ROUND_END_FRAMES(REF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .p1_got_hit     (p1_got_hit),
    .p1_got_blocked (p1_got_blocked),
    .p2_got_hit     (p2_got_hit),
    .p2_got_blocked (p2_got_blocked),
    .p1_attack_flag (p1_attack_flag),
    .p2_attack_flag (p2_attack_flag),
    .p1_stun        (p1_stun),
    .p2_stun        (p2_stun),
    .p1_stun_blocked(p1_stun_blocked),
    .p2_stun_blocked(p2_stun_blocked),
    .freeze         (freeze),
    .hit_event      (hit_event),
    .p1_score       (p1_score),
    .p2_score       (p2_score),
    .round_over     (round_over),
    .winner         (winner)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model, index 0 = P1, 1 = P2. Mode 0 fight, 1 freeze, 2 round end.
  int m_stun[2], m_blk[2], m_armed[2], m_score[2];
  int m_mode, m_hs, m_rc, m_win, m_frz, m_rov, m_hev;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_stun[i] = 0; m_blk[i] = 0; m_armed[i] = 1; m_score[i] = 0;
    end
    m_mode = 0; m_hs = 0; m_rc = 0; m_win = 0; m_frz = 0; m_rov = 0; m_hev = 0;
  endtask

  task automatic m_step();
    int hit[2], blkin[2], flag[2], ev[2];
    int any, dbl;
    m_hev = 0;
    if (frame_tick !== 1'b1) return;
    hit[0] = int'(p1_got_hit);  blkin[0] = int'(p1_got_blocked); flag[0] = int'(p1_attack_flag);
    hit[1] = int'(p2_got_hit);  blkin[1] = int'(p2_got_blocked); flag[1] = int'(p2_attack_flag);
    for (int t = 0; t < 2; t++)
      ev[t] = int'(m_mode == 0 && m_armed[1-t] == 1 && (hit[t] != 0 || blkin[t] != 0));
    any = int'(ev[0] != 0 || ev[1] != 0);
    dbl = int'(ev[0] != 0 && ev[1] != 0 && hit[0] != 0 && hit[1] != 0);
    for (int p = 0; p < 2; p++) if (flag[p] == 0) m_armed[p] = 1;
    for (int t = 0; t < 2; t++) if (ev[t] != 0) m_armed[1-t] = 0;
    m_hev = any;
    case (m_mode)
      0: begin
        if (any != 0) begin
          for (int t = 0; t < 2; t++) begin
            if (ev[t] != 0) begin
              if (hit[t] != 0 && !(dbl != 0 && !TRADE)) begin
                m_stun[t] = HIT; m_blk[t] = 0;
                if (m_score[1-t] < WIN) m_score[1-t]++;
              end else begin
                m_stun[t] = BLK; m_blk[t] = 1;
              end
            end
          end
          m_hs = HS; m_mode = 1; m_frz = 1;
        end else begin
          for (int t = 0; t < 2; t++) if (m_stun[t] > 0) m_stun[t]--;
        end
      end
      1: begin
        m_hs--;
        if (m_hs == 0) begin
          m_frz = 0;
          if (m_score[0] == WIN || m_score[1] == WIN) begin
            m_mode = 2; m_rov = 1; m_rc = REF;
            m_win = (m_score[0] == WIN ? 1 : 0) + (m_score[1] == WIN ? 2 : 0);
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        m_rc--;
        if (m_rc == 0) m_reset();
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    check("p1_stun", int'(p1_stun), int'(m_stun[0] != 0));
    check("p2_stun", int'(p2_stun), int'(m_stun[1] != 0));
    check("p1_stun_blocked", int'(p1_stun_blocked), int'(m_stun[0] != 0 && m_blk[0] != 0));
    check("p2_stun_blocked", int'(p2_stun_blocked), int'(m_stun[1] != 0 && m_blk[1] != 0));
    check("freeze", int'(freeze), m_frz);
    check("hit_event", int'(hit_event), m_hev);
    check("p1_score", int'(p1_score), m_score[0]);
    check("p2_score", int'(p2_score), m_score[1]);
    check("round_over", int'(round_over), m_rov);
    check("winner", int'(winner), m_win);
  end

  int hev_cycles = 0;
  always @(negedge clk) if (hit_event === 1'b1) hev_cycles++;

  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return freeze;
      1: return p1_stun;
      2: return p2_stun;
      default: return round_over;
    endcase
  endfunction

  task automatic count_while(input int sel, input int limit, output int n);
    n = 0;
    while (sig(sel) === 1'b1 && n < limit) begin
      do_tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fz, b;
    m_reset();
    rst = 1'b1; frame_tick = 1'b0;
    p1_got_hit = 1'b0; p1_got_blocked = 1'b0; p2_got_hit = 1'b0; p2_got_blocked = 1'b0;
    p1_attack_flag = 1'b0; p2_attack_flag = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_freeze", int'(freeze), 0);
    check("rst_p2_score", int'(p2_score), 0);
    check("rst_winner", int'(winner), 0);

    // Single clean hit on P1 at tick 5.
    repeat (4) do_tick();
    hev_cycles = 0;
    p1_got_hit = 1'b1; do_tick(); p1_got_hit = 1'b0;
    check("a_p2_score", int'(p2_score), 1);
    check("a_p1_stun", int'(p1_stun), 1);
    check("a_p1_hitstun", int'(p1_stun_blocked), 0);
    check("a_hit_event_cycles", hev_cycles, 1);
    n = 0; fz = 0;
    while (p1_stun === 1'b1 && n < 100) begin
      if (freeze === 1'b1) fz++;
      do_tick();
      n++;
    end
    check("a_freeze_ticks", fz, 6);
    check("a_stun_ticks", n, 26);

    // Held hit with attack flag high: one score per swing; re-arm then win for P2.
    p2_attack_flag = 1'b1; p1_got_hit = 1'b1;
    repeat (40) do_tick();
    check("d_one_score", int'(p2_score), 2);
    p2_attack_flag = 1'b0; do_tick();
    check("d_rearm_no_score", int'(p2_score), 2);
    p2_attack_flag = 1'b1; do_tick();
    p1_got_hit = 1'b0; p2_attack_flag = 1'b0;
    check("d_third_score", int'(p2_score), 3);
    count_while(0, 20, n);
    check("d_freeze_ticks", n, 6);
    check("d_round_over", int'(round_over), 1);
    check("d_winner_p2", int'(winner), 2);
    count_while(3, 200, n);
    check("d_round_ticks", n, 120);
    check("d_scores_cleared", int'(p2_score), 0);
    check("d_winner_cleared", int'(winner), 0);

    // Block on P2.
    p2_got_blocked = 1'b1; do_tick(); p2_got_blocked = 1'b0;
    check("b_blockstun", int'(p2_stun_blocked), 1);
    check("b_p1_score", int'(p1_score), 0);
    n = 0; b = 0;
    while (p2_stun === 1'b1 && n < 100) begin
      if (freeze === 1'b0 && p2_stun_blocked === 1'b1) b++;
      do_tick();
      n++;
    end
    check("b_fight_block_ticks", b, 12);
    check("b_stun_ticks", n, 18);
    check("b_p2_score", int'(p2_score), 0);

    // Same-tick double hit.
    p1_got_hit = 1'b1; p2_got_hit = 1'b1; do_tick(); p1_got_hit = 1'b0; p2_got_hit = 1'b0;
    check("c_p1_score", int'(p1_score), TRADE ? 1 : 0);
    check("c_p2_score", int'(p2_score), TRADE ? 1 : 0);
    check("c_p1_blocked", int'(p1_stun_blocked), TRADE ? 0 : 1);
    check("c_p2_blocked", int'(p2_stun_blocked), TRADE ? 0 : 1);
    count_while(1, 100, n);
    check("c_stun_ticks", n, TRADE ? 26 : 18);

    // P1 lands hits until the round is won.
    for (int k = 0; k < 3; k++) begin
      if (round_over === 1'b1) break;
      p2_got_hit = 1'b1; do_tick(); p2_got_hit = 1'b0;
      count_while(0, 20, n);
    end
    check("f_round_over", int'(round_over), 1);
    check("f_winner_p1", int'(winner), 1);
    check("f_p1_score", int'(p1_score), 3);
    count_while(3, 200, n);
    check("f_round_ticks", n, 120);
    check("f_p1_cleared", int'(p1_score), 0);

    // Asynchronous reset in the middle of hitstop.
    p1_got_hit = 1'b1; do_tick(); p1_got_hit = 1'b0;
    do_tick();
    check("e_freeze_before", int'(freeze), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("e_freeze_rst", int'(freeze), 0);
    check("e_stun_rst", int'(p1_stun), 0);
    check("e_score_rst", int'(p2_score), 0);
    @(negedge clk) rst = 1'b0;
    // Attack flag held high: only a reset-armed P2 can register this hit.
    p2_attack_flag = 1'b1; p1_got_hit = 1'b1; do_tick();
    p1_got_hit = 1'b0; p2_attack_flag = 1'b0;
    check("e_armed_after_rst", int'(p2_score), 1);
    repeat (10) do_tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_arbiter.md
# hit_arbiter

Frame-rate referee that sits downstream of the two per-target collision checkers, one for each direction of attack. It samples their hit and block results once per video frame and enforces one connect per swing. It also arbitrates simultaneous hits, runs hitstop and hit/block stun timers for both fighters, and keeps score until a round is won. Its stun and freeze outputs gate both fighter state machines.

## Interface
- HITSTUN_FRAMES, 20: stun frames loaded on a clean hit (1..255)
- BLOCKSTUN_FRAMES, 12: stun frames loaded on a block or clash (1..255)
- HITSTOP_FRAMES, 6: global freeze frames after any registered event (1..255)
- WIN_SCORE, 3: hits needed to win a round (1..15)
- ROUND_END_FRAMES, 120: length of the post-round hold (1..255)

- clk  in  1  system clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- p1_got_hit, p1_got_blocked  in  1  P1 is the target and P2 is the attacker
- p2_got_hit, p2_got_blocked  in  1  P2 is the target and P1 is the attacker
- p1_attack_flag, p2_attack_flag  in  1  attacker's attack phase is active
- p1_stun, p2_stun  out  1  fighter is in stun; its inputs are ignored
- p1_stun_blocked, p2_stun_blocked  out  1  current stun is blockstun (0 = hitstun)
- freeze  out  1  hitstop active; both fighters hold position and animation
- hit_event  out  1  one-cycle pulse when any event registers (sound/flash)
- p1_score, p2_score  out  4  hits landed by each player
- round_over  out  1  high during the ROUND_END state
- winner  out  2  01 = P1, 10 = P2, 11 = draw, 00 = none

## Operation
- Reset values: all outputs 0, FSM in FIGHT, both armed flags 1, all counters 0.
- All state updates happen only on clk edges where frame_tick=1. Between ticks, state holds.
- Arming:
  - armed_pN is set on a tick where pN_attack_flag=0.
  - armed_pN is cleared on a tick where an event from attacker pN registers.
- Attacker P2's raw event = p1_got_hit|p1_got_blocked. It registers only in FIGHT and only when armed_p2=1. P1 is symmetric.
- If got_hit and got_blocked are both high, the event is treated as a hit.
- Per-target effects:
  - A hit loads HITSTUN_FRAMES, sets stun_blocked=0, and adds +1 to the attacker's score.
  - A block loads BLOCKSTUN_FRAMES and sets stun_blocked=1.
  - A new event during stun reloads the counter.
- Same-tick events in both directions are applied independently, except for a double hit (see Configuration).
- Scores saturate at WIN_SCORE.
- FSM states:
  - FIGHT: on any registered event, load the hitstop counter with HITSTOP_FRAMES, pulse hit_event, and go to FREEZE. With no event, each nonzero stun counter decrements by 1.
  - FREEZE: freeze=1 and stun counters hold. Decrement the hitstop counter each tick. When it reaches 0, go to ROUND_END if either score equals WIN_SCORE, otherwise go to FIGHT.
  - ROUND_END: round_over=1. winner is set on entry (both at WIN_SCORE gives 11) and held. Counts ROUND_END_FRAMES ticks, then restores reset values except the FSM, and enters FIGHT.
- pN_stun = (stun counter != 0). pN_stun_blocked is valid only while pN_stun=1 and reads 0 otherwise.

## Timing
- All outputs are registered. An event sampled on tick T is visible on the cycle after T.
- freeze stays high for exactly HITSTOP_FRAMES ticks. It falls the cycle after the HITSTOP_FRAMES-th tick following T.
- Stun counters decrement only on FIGHT ticks. Total stun therefore spans HITSTOP_FRAMES + N frames.
- Raw inputs arriving during FREEZE or ROUND_END are dropped and never queued.
- rst mid-operation returns all state to reset values immediately, asynchronously.
- hit_event is one clk cycle wide, not one frame wide.

## Configuration
- HIT_ARBITER_TRADE_EN defined: a same-tick double hit is a trade. Both fighters get hitstun, both scores +1, and simultaneous win gives winner=11.
- Undefined: a same-tick double hit is a clash. Both fighters get BLOCKSTUN_FRAMES with stun_blocked=1, scores are unchanged, but hitstop and hit_event still occur and both armed flags clear.

## Structure
- Shared package holds:
  - FSM state encoding (FIGHT, FREEZE, ROUND_END)
  - winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW)
  - stun counter width (8) and score width (4)
- Sub-module fighter_hit_tracker, instantiated once per target. It owns the stun counter, the stun_blocked flag, and the opposing attacker's armed flag. Its inputs are load-hit, load-block, decrement-enable and arm/disarm strobes.
- Top level owns the FSM, the hitstop and round counters, double-hit arbitration, and scoring.

## Test plan
- p1_got_hit tick 5, armed -> p2_score=1, freeze high 6 ticks, p1_stun high 6+20 ticks, hit_event one cycle.
- p1_got_hit held high over 40 ticks with p2_attack_flag=1 throughout -> exactly one score; drop flag one tick and re-hit -> score=2.
- p2_got_blocked at a tick -> p2_stun_blocked=1 for 12 FIGHT ticks, scores unchanged.
- Both got_hit same tick -> TRADE_EN: both scores 1, both hitstun; without: scores 0, both blockstun 12.
- Three P1 hits -> after third freeze, round_over=1, winner=01 for 120 ticks, then scores 0 and FIGHT.
- Assert rst mid-FREEZE -> freeze, stun and scores 0 same cycle; armed flags 1.
